// File: rtl/jzjpcc_memory_pkg.sv
// Shared encodings for the memory stage: rd source select, load funct3 codes
// and the transaction FSM state type.
package jzjpcc_memory_pkg;

    localparam logic [1:0] RDSRC_ALU = 2'b00;
    localparam logic [1:0] RDSRC_MEM = 2'b01;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_t;

endpackage

// File: rtl/jzjpcc_load_extract.sv
// Load data extraction: picks the byte/halfword addressed by the low address
// bits out of the returned word and sign- or zero-extends it to 32 bits.
module jzjpcc_load_extract
    import jzjpcc_memory_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] extData
);

    logic [7:0]  selByte;
    logic [15:0] selHalf;

    // Select the addressed lane, then extend according to the load width/sign
    always_comb begin
        selByte = rdata[7:0];
        unique case (offset)
            2'd0: selByte = rdata[7:0];
            2'd1: selByte = rdata[15:8];
            2'd2: selByte = rdata[23:16];
            2'd3: selByte = rdata[31:24];
        endcase

        // Halfword loads ignore offset[0]; misaligned halves are not split
        selHalf = offset[1] ? rdata[31:16] : rdata[15:0];

        extData = rdata;
        case (funct3)
            F3_LB:   extData = {{24{selByte[7]}}, selByte};
            F3_LBU:  extData = {24'h000000, selByte};
            F3_LH:   extData = {{16{selHalf[15]}}, selHalf};
            F3_LHU:  extData = {16'h0000, selHalf};
            F3_LW:   extData = rdata;
            default: extData = rdata;
        endcase
    end

endmodule

// File: rtl/jzjpcc_memory.sv
// Memory stage: consumes the execute register, runs a req/ack transaction
// against a multi-cycle data memory and loads the writeback register.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new op; non-memory ops pass straight to writeback
// WAIT  | memory request outstanding, dmem_* held until dmem_ack
module jzjpcc_memory
    import jzjpcc_memory_pkg::*;
#(
    parameter int DMEM_ADDR_B = 12
)
(
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            aluResult,
    input  logic [4:0]             rdAddr,
    input  logic [1:0]             rdSource,
    input  logic                   rdWriteEnable,
    input  logic [2:0]             funct3,
    input  logic                   memoryWriteEnable,
    input  logic [31:0]            memDataToWrite,
    input  logic [3:0]             memByteMask,

    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [DMEM_ADDR_B-3:0] dmem_addr,
    output logic [31:0]            dmem_wdata,
    output logic [3:0]             dmem_bmask,
    input  logic                   dmem_ack,
    input  logic [31:0]            dmem_rdata,

    output logic                   wb_valid,
    output logic [4:0]             wb_rdAddr,
    output logic                   wb_rdWriteEnable,
    output logic [31:0]            wb_rdData
);

    memState_t   state;
    logic [31:0] holdAluResult;
    logic [4:0]  holdRdAddr;
    logic        holdRdWriteEnable;
    logic [2:0]  holdFunct3;
    logic        holdIsStore;
    logic [31:0] loadData;
    logic        isMemOp;

    // A store wins over rdSource; any rdSource other than MEM behaves as ALU
    assign isMemOp  = memoryWriteEnable || (rdSource == RDSRC_MEM);
    assign in_ready = (state == IDLE);

    jzjpcc_load_extract loadExtract (
        .rdata   (dmem_rdata),
        .funct3  (holdFunct3),
        .offset  (holdAluResult[1:0]),
        .extData (loadData)
    );

    // Transaction FSM, hold registers, dmem request and writeback register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= IDLE;
            holdAluResult     <= '0;
            holdRdAddr        <= '0;
            holdRdWriteEnable <= 1'b0;
            holdFunct3        <= '0;
            holdIsStore       <= 1'b0;
            dmem_req          <= 1'b0;
            dmem_we           <= 1'b0;
            dmem_addr         <= '0;
            dmem_wdata        <= '0;
            dmem_bmask        <= '0;
            wb_valid          <= 1'b0;
            wb_rdAddr         <= '0;
            wb_rdWriteEnable  <= 1'b0;
            wb_rdData         <= '0;
        end else begin
            wb_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (isMemOp) begin
                            state             <= WAIT;
                            holdAluResult     <= aluResult;
                            holdRdAddr        <= rdAddr;
                            holdRdWriteEnable <= rdWriteEnable;
                            holdFunct3        <= funct3;
                            holdIsStore       <= memoryWriteEnable;
                            dmem_req          <= 1'b1;
                            dmem_we           <= memoryWriteEnable;
                            dmem_addr         <= aluResult[DMEM_ADDR_B-1:2];
                            dmem_wdata        <= memDataToWrite;
                            dmem_bmask        <= memoryWriteEnable ? memByteMask : 4'hF;
                        end else begin
                            wb_valid         <= 1'b1;
                            wb_rdAddr        <= rdAddr;
                            wb_rdWriteEnable <= rdWriteEnable;
                            wb_rdData        <= aluResult;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state            <= IDLE;
                        dmem_req         <= 1'b0;
                        wb_valid         <= 1'b1;
                        wb_rdAddr        <= holdRdAddr;
                        wb_rdWriteEnable <= holdRdWriteEnable;
                        wb_rdData        <= holdIsStore ? holdAluResult : loadData;
                    end
                end
            endcase
        end
    end

endmodule
